// File: rtl/keyboard_key_decoder_if.sv
// keyboard_key_decoder_if
//   Groups the byte-stream input and the per-key outputs of keyboard_key_decoder.
//   master: the side that feeds received bytes and consumes key state (receiver/game logic).
//   slave : the decoder itself.
//   Signals:
//     scan_code    [7:0]       received Set 2 byte
//     scan_valid               1-cycle strobe, scan_code valid
//     clear                    force all keys released, prefix state dropped
//     key_held     [NUM_KEYS]  level: key i currently down
//     key_pressed  [NUM_KEYS]  1-cycle pulse on key i going down
//     key_released [NUM_KEYS]  1-cycle pulse on key i going up
//     key_repeat   [NUM_KEYS]  1-cycle auto-repeat pulse (zero unless repeat is built in)
interface keyboard_key_decoder_if #(
  parameter int NUM_KEYS = 5
);
  logic [7:0]          scan_code;
  logic                scan_valid;
  logic                clear;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] key_released;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output scan_code, scan_valid, clear,
    input  key_held, key_pressed, key_released, key_repeat
  );

  modport slave (
    input  scan_code, scan_valid, clear,
    output key_held, key_pressed, key_released, key_repeat
  );
endinterface

// File: rtl/keyboard_key_decoder.sv
// keyboard_key_decoder
//   PS/2 Set 2 scan-code decoder. Consumes the byte stream from a PS/2 receiver, follows the
//   E0 (extended) and F0 (break) prefixes, and keeps a held/pressed/released view of NUM_KEYS
//   configured keys. Key i is selected by KEY_CODES[8i+7:8i] and KEY_EXT[i] (1 = E0 key).
//   All outputs are registered: a byte strobed at cycle t shows its effect at t+1.
//   Ports:
//     clk    system clock
//     rst_n  synchronous reset, active low
//     bus    keyboard_key_decoder_if.slave (scan_code/scan_valid/clear in, key_* out)
//   Optional feature: define KEYBOARD_REPEAT_EN to build per-key typematic repeat counters
//   (first pulse REPEAT_DELAY cycles after press, then every REPEAT_PERIOD). Without it
//   key_repeat is constant zero and no repeat logic exists.
module keyboard_key_decoder #(
  parameter int                    NUM_KEYS       = 5,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h6B, 8'h29, 8'h1D, 8'h23, 8'h1C},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 5'b10000,
  parameter int                    PREFIX_TIMEOUT = 1_000_000,
  parameter int                    REPEAT_DELAY   = 50_000_000,
  parameter int                    REPEAT_PERIOD  = 10_000_000
) (
  input logic                   clk,
  input logic                   rst_n,
  keyboard_key_decoder_if.slave bus
);

  localparam int             TW       = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0]     CODE_EXT = 8'hE0;
  localparam logic [7:0]     CODE_BRK = 8'hF0;

  // Parameter sanity, caught at elaboration.
  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("keyboard_key_decoder: NUM_KEYS must be 1..16");
  end
  if (PREFIX_TIMEOUT < 1) begin : g_bad_timeout
    $error("keyboard_key_decoder: PREFIX_TIMEOUT must be >= 1");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("keyboard_key_decoder: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [TW-1:0]       to_cnt, to_cnt_next;
  logic                do_decode, dec_break, dec_ext;
  logic [NUM_KEYS-1:0] match, make_mask, brk_mask;
  logic [NUM_KEYS-1:0] held_p1, pressed_p1, released_p1;
  logic [NUM_KEYS-1:0] held_next, pressed_next, released_next;

  // Prefix FSM: a non-prefix byte is decoded with the accumulated E0/F0 context.
  always_comb begin
    state_next = state;
    do_decode  = 1'b0;
    dec_break  = 1'b0;
    dec_ext    = 1'b0;
    if (bus.clear) begin
      state_next = S_IDLE;
    end else if (bus.scan_valid) begin
      unique case (state)
        S_IDLE: begin
          if (bus.scan_code == CODE_EXT)      state_next = S_EXT;
          else if (bus.scan_code == CODE_BRK) state_next = S_BRK;
          else                                do_decode  = 1'b1;
        end
        S_EXT: begin
          if (bus.scan_code == CODE_BRK)      state_next = S_EXT_BRK;
          else if (bus.scan_code == CODE_EXT) state_next = S_EXT;
          else begin
            do_decode  = 1'b1;
            dec_ext    = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_BRK: begin
          if (bus.scan_code == CODE_EXT)      state_next = S_EXT_BRK;
          else if (bus.scan_code == CODE_BRK) state_next = S_BRK;
          else begin
            do_decode  = 1'b1;
            dec_break  = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: begin
          if (bus.scan_code != CODE_EXT && bus.scan_code != CODE_BRK) begin
            do_decode  = 1'b1;
            dec_break  = 1'b1;
            dec_ext    = 1'b1;
            state_next = S_IDLE;
          end
        end
      endcase
    end else if (state != S_IDLE && to_cnt == TO_LAST) begin
      // A prefix left without its follow-up byte is abandoned.
      state_next = S_IDLE;
    end
  end

  // Timeout counter: only meaningful while a prefix is pending; any byte restarts it.
  always_comb begin
    if (bus.clear || bus.scan_valid || state == S_IDLE || to_cnt == TO_LAST) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt + 1'b1;
    end
  end

  // Every key whose code and E0-ness match is updated, so duplicate entries track together.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (do_decode && KEY_CODES[8*i +: 8] == bus.scan_code && KEY_EXT[i] == dec_ext) begin
        match[i] = 1'b1;
      end
    end
    make_mask = dec_break ? '0 : match;
    brk_mask  = dec_break ? match : '0;
  end

  // Pulses fire only on real level changes: typematic makes and stray breaks are silent.
  always_comb begin
    if (bus.clear) begin
      held_next     = '0;
      pressed_next  = '0;
      released_next = held_p1;
    end else begin
      held_next     = (held_p1 | make_mask) & ~brk_mask;
      pressed_next  = make_mask & ~held_p1;
      released_next = brk_mask & held_p1;
    end
  end

  // ---- stage boundary: registered FSM, timeout and key outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      held_p1     <= '0;
      pressed_p1  <= '0;
      released_p1 <= '0;
    end else begin
      state       <= state_next;
      to_cnt      <= to_cnt_next;
      held_p1     <= held_next;
      pressed_p1  <= pressed_next;
      released_p1 <= released_next;
    end
  end

  assign bus.key_held     = held_p1;
  assign bus.key_pressed  = pressed_p1;
  assign bus.key_released = released_p1;

`ifdef KEYBOARD_REPEAT_EN
  localparam int            RW         = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0]       rep_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] repeat_p1;

  // Counter is 0 on the first held cycle; hitting REPEAT_DELAY-1 schedules a pulse and
  // reloads so the next hit is REPEAT_PERIOD cycles later. A key that is about to be
  // released (or cleared) drops its pending pulse.
  // ---- stage boundary: registered repeat counters and pulses ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!rst_n || !held_p1[i] || !held_next[i]) begin
        rep_cnt[i]   <= '0;
        repeat_p1[i] <= 1'b0;
      end else if (rep_cnt[i] == REP_FIRST) begin
        rep_cnt[i]   <= REP_RELOAD;
        repeat_p1[i] <= 1'b1;
      end else begin
        rep_cnt[i]   <= rep_cnt[i] + 1'b1;
        repeat_p1[i] <= 1'b0;
      end
    end
  end

  assign bus.key_repeat = repeat_p1;
`else
  assign bus.key_repeat = '0;
`endif

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// tb_keyboard_key_decoder
//   Directed scenarios with literal expectations, then a long randomized byte stream with
//   occasional clear and reset. A behavioural model (held set + pending-prefix flags + idle
//   count + per-key hold age) predicts every output, compared on each falling edge.
module tb_keyboard_key_decoder;

  localparam int              NK    = 5;
  localparam int              PT    = 8;
  localparam int              RD    = 10;
  localparam int              RP    = 4;
  localparam logic [NK*8-1:0] CODES = {8'h6B, 8'h29, 8'h1D, 8'h23, 8'h1C};
  localparam logic [NK-1:0]   EXTS  = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keyboard_key_decoder_if #(.NUM_KEYS(NK)) bus ();

  keyboard_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     (CODES),
    .KEY_EXT       (EXTS),
    .PREFIX_TIMEOUT(PT),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_ext, m_brk;
  int          m_quiet;
  logic [NK-1:0] m_held, m_pressed, m_released, m_repeat, old_held;
  int          m_age [NK];

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    old_held   = m_held;
    m_pressed  = '0;
    m_released = '0;
    m_repeat   = '0;
    if (!rst_n) begin
      m_held = '0; m_ext = 0; m_brk = 0; m_quiet = 0;
    end else if (bus.clear) begin
      m_released = m_held;
      m_held = '0; m_ext = 0; m_brk = 0; m_quiet = 0;
    end else if (bus.scan_valid) begin
      m_quiet = 0;
      if (bus.scan_code == 8'hE0) m_ext = 1;
      else if (bus.scan_code == 8'hF0) m_brk = 1;
      else begin
        for (int i = 0; i < NK; i++) begin
          if (CODES[8*i +: 8] == bus.scan_code && EXTS[i] == m_ext) begin
            if (m_brk) begin
              if (m_held[i]) m_released[i] = 1'b1;
              m_held[i] = 1'b0;
            end else begin
              if (!m_held[i]) m_pressed[i] = 1'b1;
              m_held[i] = 1'b1;
            end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_quiet == PT - 1) begin
        m_ext = 0; m_brk = 0; m_quiet = 0;
      end else begin
        m_quiet++;
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (m_held[i]) m_age[i] = old_held[i] ? m_age[i] + 1 : 0;
      else           m_age[i] = 0;
`ifdef KEYBOARD_REPEAT_EN
      if (m_held[i] && m_age[i] >= RD && (m_age[i] - RD) % RP == 0) m_repeat[i] = 1'b1;
`endif
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("held",     bus.key_held,     m_held);
      check("pressed",  bus.key_pressed,  m_pressed);
      check("released", bus.key_released, m_released);
      check("repeat",   bus.key_repeat,   m_repeat);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] tbl [8];

  initial begin
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.clear      = 1'b0;
    for (int i = 0; i < NK; i++) m_age[i] = 0;
    m_held = '0; m_ext = 0; m_brk = 0; m_quiet = 0;

    // Reset with random traffic
    repeat (3) begin
      bus.scan_code  = 8'($urandom);
      bus.scan_valid = 1'($urandom);
      @(negedge clk);
    end
    check("rst_held",     bus.key_held,     '0);
    check("rst_pressed",  bus.key_pressed,  '0);
    check("rst_released", bus.key_released, '0);
    check("rst_repeat",   bus.key_repeat,   '0);
    bus.scan_valid = 1'b0;
    rst_n = 1'b1;

    // Make / break
    send(8'h1C);
    check("mk_held", bus.key_held, 5'b00001);
    check("mk_pressed", bus.key_pressed, 5'b00001);
    check("mk_model", m_held, 5'b00001);
    idle(1);
    check("mk_pulse_end", bus.key_pressed, 5'b00000);
    send(8'hF0); send(8'h1C);
    check("brk_held", bus.key_held, 5'b00000);
    check("brk_released", bus.key_released, 5'b00001);

    // Extended
    send(8'hE0); send(8'h6B);
    check("ext_held", bus.key_held, 5'b10000);
    send(8'h6B);
    check("bare_held", bus.key_held, 5'b10000);
    check("bare_pressed", bus.key_pressed, 5'b00000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("extbrk_held", bus.key_held, 5'b00000);
    check("extbrk_released", bus.key_released, 5'b10000);

    // Typematic and multiple keys
    send(8'h1C);
    check("typ_first", bus.key_pressed, 5'b00001);
    send(8'h1C);
    check("typ_second", bus.key_pressed, 5'b00000);
    send(8'h1C); send(8'h23);
    check("multi_held", bus.key_held, 5'b00011);
    check("multi_model", m_held, 5'b00011);
    send(8'hF0); send(8'h23);
    check("multi_brk", bus.key_held, 5'b00001);

    // Prefix still live one cycle short of the timeout
    send(8'hF0); idle(PT - 2); send(8'h1C);
    check("to_short_rel", bus.key_released, 5'b00001);
    check("to_short_held", bus.key_held, 5'b00000);
    // Prefix expired after PREFIX_TIMEOUT idle cycles: byte is a make
    send(8'hF0); idle(PT - 1); send(8'h1C);
    check("to_make_held", bus.key_held, 5'b00001);
    check("to_make_pressed", bus.key_pressed, 5'b00001);

    // Clear beats a simultaneous byte
    @(negedge clk);
    bus.scan_code = 8'h1D; bus.scan_valid = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0; bus.clear = 1'b0;
    check("clr_held", bus.key_held, 5'b00000);
    check("clr_released", bus.key_released, 5'b00001);
    idle(1);
    check("clr_after", bus.key_held, 5'b00000);
    // Clear drops a pending E0
    send(8'hE0);
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
    send(8'h6B);
    check("clr_prefix", bus.key_held, 5'b00000);

`ifdef KEYBOARD_REPEAT_EN
    send(8'h1C);
    idle(RD - 1);
    check("rep_early", bus.key_repeat, 5'b00000);
    idle(1);
    check("rep_first", bus.key_repeat, 5'b00001);
    idle(RP);
    check("rep_second", bus.key_repeat, 5'b00001);
    idle(RP);
    check("rep_third", bus.key_repeat, 5'b00001);
    send(8'hF0); send(8'h1C);
    idle(RD + RP);
    check("rep_stop", bus.key_repeat, 5'b00000);
`endif

    // Randomized stream
    tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h00};
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n          = ($urandom_range(0, 599) != 0);
      bus.clear      = ($urandom_range(0, 149) == 0);
      bus.scan_valid = ($urandom_range(0, 2) == 0);
      bus.scan_code  = tbl[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) bus.scan_code = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.clear = 1'b0; bus.scan_valid = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
